// File: rtl/dht_uart_reporter.sv
// Formats a DHT11 reading as "T=ddd.d,H=ddd.d\r\n" and sends it as 8N1 UART
// bytes every time data_valid rises; one newer reading can wait behind a busy frame.
module dht_uart_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [7:0]  T_integral,
  input  logic [7:0]  T_decimal,
  input  logic [7:0]  RH_integral,
  input  logic [7:0]  RH_decimal,
  input  logic        data_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  ustate_t     ustate;
  logic        dv_q;
  logic        armed;
  logic        trigger;
  logic [7:0]  t_bin, rh_bin, t_dec, rh_dec;
  logic [11:0] t_bcd, rh_bcd;
  logic [19:0] t_next, rh_next;
  logic [2:0]  conv_cnt;
  logic        pend;
  logic [7:0]  pend_t_int, pend_t_dec, pend_rh_int, pend_rh_dec;
  logic [4:0]  byte_idx, byte_sel;
  logic [15:0] bit_timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg, cur_byte;

  // armed stays low after reset until data_valid has been seen low, so a level
  // already high at release cannot masquerade as a fresh reading.
  assign trigger = data_valid & ~dv_q & armed;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [19:0] dd_step(input logic [11:0] bcd, input logic [7:0] bin);
    logic [11:0] adj;
    adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    return {adj[10:0], bin, 1'b0};
  endfunction

  function automatic logic [7:0] dec_ascii(input logic [7:0] v);
    return (v > 8'd9) ? 8'h39 : 8'h30 + v;
  endfunction

  assign t_next  = dd_step(t_bcd, t_bin);
  assign rh_next = dd_step(rh_bcd, rh_bin);

  // Byte feeding the serialiser: current slot when starting a frame, next slot
  // when chaining straight out of a stop bit.
  always_comb begin
    byte_sel = (ustate == U_IDLE) ? byte_idx : byte_idx + 5'd1;
    cur_byte = 8'h0A;
    case (byte_sel)
      5'd0:  cur_byte = 8'h54;
      5'd1:  cur_byte = 8'h3D;
      5'd2:  cur_byte = {4'h3, t_bcd[11:8]};
      5'd3:  cur_byte = {4'h3, t_bcd[7:4]};
      5'd4:  cur_byte = {4'h3, t_bcd[3:0]};
      5'd5:  cur_byte = 8'h2E;
      5'd6:  cur_byte = dec_ascii(t_dec);
      5'd7:  cur_byte = 8'h2C;
      5'd8:  cur_byte = 8'h48;
      5'd9:  cur_byte = 8'h3D;
      5'd10: cur_byte = {4'h3, rh_bcd[11:8]};
      5'd11: cur_byte = {4'h3, rh_bcd[7:4]};
      5'd12: cur_byte = {4'h3, rh_bcd[3:0]};
      5'd13: cur_byte = 8'h2E;
      5'd14: cur_byte = dec_ascii(rh_dec);
      5'd15: cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ustate      <= U_IDLE;
      dv_q        <= 1'b0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      uart_tx     <= 1'b1;
      frames_sent <= '0;
      t_bin       <= '0;
      rh_bin      <= '0;
      t_dec       <= '0;
      rh_dec      <= '0;
      t_bcd       <= '0;
      rh_bcd      <= '0;
      conv_cnt    <= '0;
      pend        <= 1'b0;
      pend_t_int  <= '0;
      pend_t_dec  <= '0;
      pend_rh_int <= '0;
      pend_rh_dec <= '0;
      byte_idx    <= '0;
      bit_timer   <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
    end else begin
      dv_q  <= data_valid;
      armed <= armed | ~data_valid;
      if (trigger && state != IDLE) begin
        pend        <= 1'b1;
        pend_t_int  <= T_integral;
        pend_t_dec  <= T_decimal;
        pend_rh_int <= RH_integral;
        pend_rh_dec <= RH_decimal;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            t_bin    <= T_integral;
            rh_bin   <= RH_integral;
            t_dec    <= T_decimal;
            rh_dec   <= RH_decimal;
            t_bcd    <= '0;
            rh_bcd   <= '0;
            conv_cnt <= '0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          t_bcd    <= t_next[19:8];
          t_bin    <= t_next[7:0];
          rh_bcd   <= rh_next[19:8];
          rh_bin   <= rh_next[7:0];
          conv_cnt <= conv_cnt + 3'd1;
          if (conv_cnt == 3'd7) begin
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          case (ustate)
            U_IDLE: begin
              shreg     <= cur_byte;
              uart_tx   <= 1'b0;
              bit_timer <= '0;
              ustate    <= U_START;
            end
            U_START: begin
              if (bit_timer == BIT_LAST) begin
                bit_timer <= '0;
                uart_tx   <= shreg[0];
                shreg     <= shreg >> 1;
                bit_idx   <= '0;
                ustate    <= U_DATA;
              end else begin
                bit_timer <= bit_timer + 16'd1;
              end
            end
            U_DATA: begin
              if (bit_timer == BIT_LAST) begin
                bit_timer <= '0;
                if (bit_idx == 3'd7) begin
                  uart_tx <= 1'b1;
                  ustate  <= U_STOP;
                end else begin
                  uart_tx <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= bit_idx + 3'd1;
                end
              end else begin
                bit_timer <= bit_timer + 16'd1;
              end
            end
            U_STOP: begin
              if (bit_timer != BIT_LAST) begin
                bit_timer <= bit_timer + 16'd1;
              end else if (byte_idx != 5'd16) begin
                bit_timer <= '0;
                byte_idx  <= byte_idx + 5'd1;
                shreg     <= cur_byte;
                uart_tx   <= 0;
                ustate    <= U_START;
              end else begin
                // Frame end: a trigger landing on this very edge is the newest reading.
                bit_timer   <= '0;
                ustate      <= U_IDLE;
                frames_sent <= frames_sent + 16'd1;
                if (trigger || pend) begin
                  t_bin    <= trigger ? T_integral  : pend_t_int;
                  t_dec    <= trigger ? T_decimal   : pend_t_dec;
                  rh_bin   <= trigger ? RH_integral : pend_rh_int;
                  rh_dec   <= trigger ? RH_decimal  : pend_rh_dec;
                  t_bcd    <= '0;
                  rh_bcd   <= '0;
                  conv_cnt <= '0;
                  pend     <= 1'b0;
                  state    <= CONVERT;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
            end
            default: ustate <= U_IDLE;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
